// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle MIPS core.
// Word RAM plus cycle counter, down-count timer and output FIFO in MMIO space.
module data_mem_mmio #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULLV = (PW+1)'(FIFO_DEPTH);

  logic [31:0] ram  [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [31:0] cycles, load, count;
  logic        en, auto_r, irq, ovf;
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;

  logic        mmio;
  logic [29:0] word;
  logic        wr_load, wr_ctrl, wr_fifo, wr_stat;
  logic        pop, accept, expire, fempty, ffull;
  logic        unused_lsb;

  assign unused_lsb = ^addr[1:0];

  assign mmio = addr >= MMIO_BASE;
  assign word = addr[31:2] - MMIO_BASE[31:2];

  assign wr_load = memwrite & mmio & (word == 30'd1);
  assign wr_ctrl = memwrite & mmio & (word == 30'd2);
  assign wr_fifo = memwrite & mmio & (word == 30'd4);
  assign wr_stat = memwrite & mmio & (word == 30'd5);

  assign fempty = cnt == '0;
  assign ffull  = cnt == FULLV;
  assign pop    = !fempty & out_ready;
  assign accept = wr_fifo & (!ffull | pop);
  assign expire = en & (count == '0);

  assign out_valid = !fempty;
  assign out_data  = fifo[rp];
  assign timer_irq = irq;

  always_ff @(posedge clk) begin
    if (memwrite && !mmio)
      ram[addr[2 +: AW]] <= writedata;
    if (accept)
      fifo[wp] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
      load   <= '0;
      count  <= '0;
      en     <= 1'b0;
      auto_r <= 1'b0;
      irq    <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (wr_ctrl) begin
        en     <= writedata[0];
        auto_r <= writedata[1];
        if (writedata[2])
          irq <= 1'b0;
      end
      // Expiry is applied after the CTRL write so a same-cycle set beats W1C
      if (en) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else begin
          irq <= 1'b1;
          if (auto_r)
            count <= load;
          else
            en <= 1'b0;
        end
      end
      if (wr_load) begin
        load  <= writedata;
        count <= writedata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (accept && !pop)
        cnt <= cnt + 1'b1;
      else if (!accept && pop)
        cnt <= cnt - 1'b1;
      if (wr_stat && writedata[2])
        ovf <= 1'b0;
      if (wr_fifo && !accept)
        ovf <= 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    if (mmio) begin
      case (word)
        30'd0:   readdata = cycles;
        30'd1:   readdata = load;
        30'd2:   readdata = {29'b0, irq, auto_r, en};
        30'd3:   readdata = count;
        30'd5:   readdata = {16'b0, 8'(cnt), 5'b0, ovf, ffull, fempty};
        default: readdata = '0;
      endcase
    end else begin
      readdata = ram[addr[2 +: AW]];
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM/register table, then timer,
// FIFO and reset sequences with hand-computed expectations.
module tb_data_mem_mmio;

  localparam logic [31:0] B      = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = B + 32'h00;
  localparam logic [31:0] A_LOAD = B + 32'h04;
  localparam logic [31:0] A_CTRL = B + 32'h08;
  localparam logic [31:0] A_CNT  = B + 32'h0C;
  localparam logic [31:0] A_FIFO = B + 32'h10;
  localparam logic [31:0] A_STAT = B + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        timer_irq;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [24];

  data_mem_mmio dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .addr(addr),
    .writedata(writedata),
    .readdata(readdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, readdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1;
    addr = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b1, 32'h10,         32'hDEADBEEF, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h10,         32'h0,        1'b1, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 32'h110,        32'h0,        1'b1, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 32'h14,         32'h12345678, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 32'h14,         32'h0,        1'b1, 32'h12345678};
    tv[5]  = '{1'b0, 32'h10,         32'h0,        1'b1, 32'hDEADBEEF};
    tv[6]  = '{1'b1, 32'h18,         32'hAAAA5555, 1'b0, 32'h0};
    tv[7]  = '{1'b1, B + 32'h18,     32'h0BAD0BAD, 1'b1, 32'h0};
    tv[8]  = '{1'b0, 32'h18,         32'h0,        1'b1, 32'hAAAA5555};
    tv[9]  = '{1'b0, A_LOAD,         32'h0,        1'b1, 32'h0};
    tv[10] = '{1'b0, A_CTRL,         32'h0,        1'b1, 32'h0};
    tv[11] = '{1'b0, A_CNT,          32'h0,        1'b1, 32'h0};
    tv[12] = '{1'b0, A_FIFO,         32'h0,        1'b1, 32'h0};
    tv[13] = '{1'b0, A_STAT,         32'h0,        1'b1, 32'h1};
    tv[14] = '{1'b1, A_LOAD,         32'h5,        1'b1, 32'h0};
    tv[15] = '{1'b0, A_LOAD,         32'h0,        1'b1, 32'h5};
    tv[16] = '{1'b0, A_CNT,          32'h0,        1'b1, 32'h5};
    tv[17] = '{1'b1, A_CTRL,         32'hFFFFFFF8, 1'b1, 32'h0};
    tv[18] = '{1'b0, A_CTRL,         32'h0,        1'b1, 32'h0};
    tv[19] = '{1'b0, A_CNT,          32'h0,        1'b1, 32'h5};
    tv[20] = '{1'b1, 32'hFFFEFFFC,   32'h77,       1'b0, 32'h0};
    tv[21] = '{1'b0, 32'h000000FC,   32'h0,        1'b1, 32'h77};
    tv[22] = '{1'b1, A_STAT,         32'hFFFFFFFF, 1'b1, 32'h1};
    tv[23] = '{1'b0, A_STAT,         32'h0,        1'b1, 32'h1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    rd("rst_status", A_STAT, 32'h1);
    rd("rst_cycles", A_CYC, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // RAM and register table
    foreach (tv[i]) begin
      @(negedge clk);
      memwrite = tv[i].we;
      addr = tv[i].a;
      writedata = tv[i].wd;
      #1;
      if (tv[i].chk)
        chk($sformatf("vec%0d_rd", i), readdata, tv[i].exp);
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h0);
      chk($sformatf("vec%0d_irq", i), {31'b0, timer_irq}, 32'h0);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
    end

    // cycle counter: 10 cycles after reset release, then wrap
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    addr = A_CYC;
    repeat (10) @(posedge clk);
    #1;
    chk("cycles_10", readdata, 32'd10);
    @(negedge clk);
    force dut.cycles = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.cycles;
    tick();
    rd("cycles_max", A_CYC, 32'hFFFF_FFFF);
    tick();
    rd("cycles_wrap", A_CYC, 32'h0);

    // one-shot timer
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h1);
    rd("os_c3", A_CNT, 32'd3);
    tick();
    rd("os_c2", A_CNT, 32'd2);
    tick();
    rd("os_c1", A_CNT, 32'd1);
    tick();
    rd("os_c0", A_CNT, 32'd0);
    chk("os_irq_pre", {31'b0, timer_irq}, 32'h0);
    tick();
    chk("os_irq", {31'b0, timer_irq}, 32'h1);
    rd("os_ctrl", A_CTRL, 32'h4);
    tick();
    rd("os_hold", A_CNT, 32'd0);
    wr(A_CTRL, 32'h4);
    chk("w1c_irq", {31'b0, timer_irq}, 32'h0);
    rd("w1c_ctrl", A_CTRL, 32'h0);

    // auto-reload timer
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h3);
    repeat (3) tick();
    rd("ar_c0", A_CNT, 32'd0);
    tick();
    rd("ar_reload", A_CNT, 32'd3);
    rd("ar_ctrl", A_CTRL, 32'h7);
    tick();
    rd("ar_c2", A_CNT, 32'd2);
    wr(A_CTRL, 32'h7);
    chk("ar_w1c", {31'b0, timer_irq}, 32'h0);
    rd("ar_c1", A_CNT, 32'd1);
    tick();
    rd("ar_c0b", A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    chk("set_wins", {31'b0, timer_irq}, 32'h1);
    rd("set_wins_cnt", A_CNT, 32'd3);
    wr(A_CTRL, 32'h4);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h3);
    rd("lw_c1", A_CNT, 32'd1);
    tick();
    rd("lw_c0", A_CNT, 32'd0);
    wr(A_LOAD, 32'd9);
    rd("load_wins", A_CNT, 32'd9);
    chk("load_wins_irq", {31'b0, timer_irq}, 32'h1);
    wr(A_CTRL, 32'h4);
    rd("stop_c8", A_CNT, 32'd8);
    tick();
    rd("stop_hold", A_CNT, 32'd8);

    // FIFO overflow then drain
    for (int i = 1; i <= 5; i++)
      wr(A_FIFO, 32'(i));
    rd("ovf_status", A_STAT, 32'h0406);
    chk("ovf_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("drain%0d", i), out_data, 32'(i));
      chk($sformatf("drain%0d_v", i), {31'b0, out_valid}, 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drained_v", {31'b0, out_valid}, 32'h0);
    rd("drained_status", A_STAT, 32'h0005);
    wr(A_STAT, 32'h4);
    rd("ovf_w1c", A_STAT, 32'h0001);

    // push into a full FIFO while it pops
    for (int i = 10; i <= 13; i++)
      wr(A_FIFO, 32'(i));
    rd("full_status", A_STAT, 32'h0402);
    out_ready = 1'b1;
    wr(A_FIFO, 32'd14);
    out_ready = 1'b0;
    rd("pp_status", A_STAT, 32'h0402);
    chk("pp_head", out_data, 32'd11);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      #1;
      chk($sformatf("pp_drain%0d", i), out_data, 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    rd("pp_empty", A_STAT, 32'h0001);

    // reset mid-operation
    wr(A_FIFO, 32'hA1);
    wr(A_FIFO, 32'hA2);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h3);
    repeat (2) tick();
    chk("pre_rst_irq", {31'b0, timer_irq}, 32'h1);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("mr_valid", {31'b0, out_valid}, 32'h0);
    chk("mr_irq", {31'b0, timer_irq}, 32'h0);
    rd("mr_count", A_CNT, 32'h0);
    rd("mr_cycles", A_CYC, 32'h0);
    rd("mr_ctrl", A_CTRL, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    rd("mr_stopped", A_CNT, 32'h0);
    rd("mr_status", A_STAT, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
